func_cmos: RTL and testbench

- Four-input Boolean function block built as a transistor-level static CMOS complex gate, with a registered output stage.
- Takes true and complement rails for a, b, c, d.
- Evaluates F = (a·_b) + (_c·d) + (b·c·_d) and presents F on output1 one clock after sampling.
- Sits as a leaf cell in the gate-level datapath. Upstream logic supplies both polarities of each input.

---
 rtl/func_cmos_pkg.sv | 6 +
 rtl/func_cmos_core.sv | 51 +++++
 rtl/func_cmos.sv | 49 ++++
 tb/tb_func_cmos.sv | 130 +++++++++++++
 4 files changed

// File: rtl/func_cmos_pkg.sv
// rtl/func_cmos_pkg.sv - shared constants for the func_cmos leaf cell
package func_cmos_pkg;

  localparam logic OUTPUT1_RST = 1'b0;

endpackage

// File: rtl/func_cmos_core.sv
// rtl/func_cmos_core.sv - static CMOS complex gate, F = a._b + _c.d + b.c._d
// Switch-level netlist: nmos pull-down and dual pmos pull-up build Fn, an inverter restores F.
module func_cmos_core (
  output wire F,
  input  wire a,
  input  wire b,
  input  wire c,
  input  wire d,
  input  wire _a,
  input  wire _b,
  input  wire _c,
  input  wire _d
);

  supply1 vdd;
  supply0 gnd;

  wire fn;
  wire pu_n1;
  wire pu_n2;
  wire pd_m1;
  wire pd_m2;
  wire pd_m3;
  wire pd_m4;
  wire a_unused;

  // _a has no device in either network; it terminates on a sink buffer
  buf u_a_sink (a_unused, _a);

  // Pull-up: (a || _b) in series with (_c || d) in series with (b || c || _d)
  pmos p_g1_a  (pu_n1, vdd,   a);
  pmos p_g1_b  (pu_n1, vdd,   _b);
  pmos p_g2_c  (pu_n2, pu_n1, _c);
  pmos p_g2_d  (pu_n2, pu_n1, d);
  pmos p_g3_b  (fn,    pu_n2, b);
  pmos p_g3_c  (fn,    pu_n2, c);
  pmos p_g3_d  (fn,    pu_n2, _d);

  // Pull-down: (a,_b) || (_c,d) || (b,c,_d)
  nmos n_t1_a  (pd_m1, gnd,   a);
  nmos n_t1_b  (fn,    pd_m1, _b);
  nmos n_t2_c  (pd_m2, gnd,   _c);
  nmos n_t2_d  (fn,    pd_m2, d);
  nmos n_t3_b  (pd_m3, gnd,   b);
  nmos n_t3_c  (pd_m4, pd_m3, c);
  nmos n_t3_d  (fn,    pd_m4, _d);

  pmos p_inv   (F, vdd, fn);
  nmos n_inv   (F, gnd, fn);

endmodule

// File: rtl/func_cmos.sv
// rtl/func_cmos.sv - func_cmos leaf cell: CMOS core plus reset-gated output register
module func_cmos
  import func_cmos_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic _a,
  input  logic _b,
  input  logic _c,
  input  logic _d,
  output logic output1
);

  wire  f_core;
  logic output1_d;
  logic output1_q;

  func_cmos_core u_core (
    .F  (f_core),
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    ._a (_a),
    ._b (_b),
    ._c (_c),
    ._d (_d)
  );

  always_comb begin
    output1_d = f_core;
  end

  // Only the flop is visible outside, so core glitches never propagate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      output1_q <= OUTPUT1_RST;
    end else begin
      output1_q <= output1_d;
    end
  end

  assign output1 = output1_q;

endmodule

// File: tb/tb_func_cmos.sv
// tb/tb_func_cmos.sv - self-checking bench for func_cmos
module tb_func_cmos;

  logic clk;
  logic rst_n;
  logic ra, rb, rc, rd;
  logic na, nb, nc, nd;
  logic output1;

  int checks;
  int fails;

  // Truth table from the minterm list, bit index = {a,b,c,d}
  logic [15:0] tt;

  func_cmos dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (ra),
    .b       (rb),
    .c       (rc),
    .d       (rd),
    ._a      (na),
    ._b      (nb),
    ._c      (nc),
    ._d      (nd),
    .output1 (output1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_f(input logic a, b, c, d, nb_i, nc_i, nd_i);
    return (a & nb_i) | (nc_i & d) | (b & c & nd_i);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input logic [3:0] v);
    {ra, rb, rc, rd} = v;
    {na, nb, nc, nd} = ~v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_core(input string tag, input logic exp);
    #1;
    chk(tag, $isunknown(dut.f_core) ? 1'bx : dut.f_core, exp);
  endtask

  logic exp_next;
  logic [7:0] rv;

  initial begin
    checks = 0;
    fails  = 0;
    tt     = 16'b0110_1111_0110_0010;
    rst_n  = 1'b0;
    set_vec(4'b1111);

    step();
    chk("reset_hold_0", output1, 1'b0);
    step();
    chk("reset_hold_1", output1, 1'b0);
    rst_n = 1'b1;
    step();
    chk("reset_release_f1111", output1, 1'b0);

    // Exhaustive sweep with consistent rails, core checked before each edge
    for (int i = 0; i < 16; i++) begin
      set_vec(4'(i));
      chk_core($sformatf("core_vec%0d", i), tt[i]);
      step();
      chk($sformatf("sweep_vec%0d", i), output1, tt[i]);
    end

    set_vec(4'b1001);
    rst_n = 1'b0;
    step();
    chk("midreset_clear", output1, 1'b0);
    rst_n = 1'b1;
    step();
    chk("midreset_resume", output1, 1'b1);

    set_vec(4'b0000);
    step();
    chk("latency_pre", output1, 1'b0);
    set_vec(4'b1000);
    #1;
    chk("latency_before_edge", output1, 1'b0);
    step();
    chk("latency_rise", output1, 1'b1);
    set_vec(4'b0000);
    step();
    chk("latency_fall", output1, 1'b0);

    ra = 1'b0; rb = 1'b1; rc = 1'b0; rd = 1'b1;
    nb = 1'b0; nc = 1'b1; nd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      na = i[0];
      step();
      chk($sformatf("unused_a_%0d", i), output1, 1'b1);
    end

    // Random rails, including inconsistent pairs, and random reset pulses
    for (int i = 0; i < 200; i++) begin
      rv = 8'($urandom);
      {ra, rb, rc, rd, na, nb, nc, nd} = rv;
      rst_n = ($urandom_range(0, 7) != 0);
      exp_next = rst_n ? ref_f(ra, rb, rc, rd, nb, nc, nd) : 1'b0;
      chk_core($sformatf("rand_core_%0d", i), ref_f(ra, rb, rc, rd, nb, nc, nd));
      step();
      chk($sformatf("rand_out_%0d", i), output1, exp_next);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
